// File: rtl/alu_muldiv_seq.sv
// Registered EX-stage ALU with iterative RV32M multiply/divide/remainder behind valid/ready.
// Define ALU_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle multiplier.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;        // multiplicand
  logic [WIDTH-1:0]   b_q;        // divisor magnitude
  logic [2*WIDTH-1:0] prod_q;     // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [SHW-1:0]     cnt;
  logic               neg_quo_q;
  logic               neg_rem_q;

  logic               accept;
  logic [WIDTH-1:0]   imm_result;
  logic               imm_dbz;
  logic               needs_iter;
  logic               signed_div;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [SHW-1:0]     shamt;

  assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
  assign accept     = in_valid && in_ready;
  assign shamt      = b[SHW-1:0];
  assign signed_div = (alu_control == OP_DIV) || (alu_control == OP_REM);
  assign abs_a      = (signed_div && a[WIDTH-1]) ? -a : a;
  assign abs_b      = (signed_div && b[WIDTH-1]) ? -b : b;

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  // Single-cycle decode; also flags the ops that must go through BUSY.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    imm_result = '0;
    imm_dbz    = 1'b0;
    needs_iter = 1'b0;
    case (alu_control)
      OP_AND:  imm_result = a & b;
      OP_OR:   imm_result = a | b;
      OP_ADD:  imm_result = a + b;
      OP_XOR:  imm_result = a ^ b;
      OP_SLL:  imm_result = a << shamt;
      OP_SRL:  imm_result = a >> shamt;
      OP_SUB:  imm_result = a - b;
      OP_SRA:  imm_result = $signed(a) >>> shamt;
      OP_SLT:  imm_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: imm_result = {{(WIDTH-1){1'b0}}, a < b};
      OP_MUL, OP_MULHU: begin
`ifdef ALU_FAST_MUL_EN
        imm_result = alu_control[0] ? fast_prod[2*WIDTH-1:WIDTH] : fast_prod[WIDTH-1:0];
`else
        needs_iter = 1'b1;
`endif
      end
      OP_DIV, OP_REM: begin
        if (b == '0) begin
          imm_dbz    = 1'b1;
          imm_result = alu_control[1] ? a : '1;
        end else if (a == MIN_VAL && b == '1) begin
          imm_result = alu_control[1] ? '0 : MIN_VAL;
        end else begin
          needs_iter = 1'b1;
        end
      end
      OP_DIVU, OP_REMU: begin
        if (b == '0) begin
          imm_dbz    = 1'b1;
          imm_result = alu_control[1] ? a : '1;
        end else begin
          needs_iter = 1'b1;
        end
      end
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  logic               iter_mul;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   iter_result;

  assign iter_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign div_diff = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]} - {1'b0, b_q};
  assign quo_next = prod_next[WIDTH-1:0];
  assign rem_next = prod_next[2*WIDTH-1:WIDTH];

  always_comb begin
    if (iter_mul)
      prod_next = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
    else if (div_diff[WIDTH])
      prod_next = {prod_q[2*WIDTH-2:0], 1'b0};
    else
      prod_next = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    iter_result = quo_next;
    if (op_q == OP_MULHU || op_q == OP_REMU) iter_result = rem_next;
    else if (op_q == OP_DIV)                 iter_result = neg_quo_q ? -quo_next : quo_next;
    else if (op_q == OP_REM)                 iter_result = neg_rem_q ? -rem_next : rem_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every internal register is reset so an aborted op leaves no stale partial state.
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      lt          <= 1'b0;
      div_by_zero <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      cnt         <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      op_q <= alu_control;
      cnt  <= '0;
      if (needs_iter) begin
        state     <= BUSY;
        out_valid <= 1'b0;
        a_q       <= a;
        b_q       <= abs_b;
        prod_q    <= {{WIDTH{1'b0}}, iter_mul_start(alu_control) ? b : abs_a};
        neg_quo_q <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_q <= signed_div && a[WIDTH-1];
      end else begin
        state       <= DONE;
        out_valid   <= 1'b1;
        result      <= imm_result;
        zero        <= (imm_result == '0);
        lt          <= (alu_control == OP_SLT || alu_control == OP_SLTU) && imm_result[0];
        div_by_zero <= imm_dbz;
      end
    end else begin
      case (state)
        BUSY: begin
          prod_q <= prod_next;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH-1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            result      <= iter_result;
            zero        <= (iter_result == '0);
            lt          <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic iter_mul_start(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq (WIDTH=32); honours ALU_FAST_MUL_EN.
module tb_alu_muldiv_seq;

  localparam int W = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SUB = 4'b0110, OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000, OP_SLTU = 4'b1001, OP_MUL = 4'b1010, OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIV = 4'b1100, OP_DIVU = 4'b1101, OP_REM = 4'b1110, OP_REMU = 4'b1111;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         l;
    logic         d;
    logic [7:0]   lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_control = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         lt;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .lt(lt), .div_by_zero(div_by_zero)
  );

  // Called 1 time unit after a rising edge; returns with the result sampled, latency in cycles.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                        output logic [W-1:0] r, output logic z, output logic l, output logic d,
                        output int lat);
    in_valid = 1'b1; alu_control = op; a = va; b = vb;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_control = ~op; a = ~va; b = vb ^ 32'h0000_0005;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; z = zero; l = lt; d = div_by_zero;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({out_valid, zero, lt, div_by_zero, in_ready} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_flags: got ov/z/lt/dbz/rdy=%b want 00001",
               {out_valid, zero, lt, div_by_zero, in_ready});
    end
    n_vec++;
    if (result !== '0) begin
      n_err++;
      $display("FAIL reset_result: got %h want 0", result);
    end
  endtask

  task automatic test_base_ops();
    vec_t tbl [11];
    logic [W-1:0] r; logic z, l, d; int lat;
    tbl = '{
      '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'd1},
      '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 8'd1},
      '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 8'd1},
      '{OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 8'd1},
      '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0, 8'd1},
      '{OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 8'd1},
      '{OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 8'd1},
      '{OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 8'd1},
      '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 8'd1},
      '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'd1},
      '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 8'd1}
    };
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, l, d, lat);
      n_vec++;
      if ({r, z, l, d, 8'(lat)} !== {tbl[i].res, tbl[i].z, tbl[i].l, tbl[i].d, tbl[i].lat}) begin
        n_err++;
        $display("FAIL base[%0d] op=%b: got res=%h z=%b lt=%b dbz=%b lat=%0d want res=%h z=%b lt=%b dbz=%b lat=%0d",
                 i, tbl[i].op, r, z, l, d, lat, tbl[i].res, tbl[i].z, tbl[i].l, tbl[i].d, tbl[i].lat);
      end
    end
  endtask

  task automatic test_mul();
    vec_t tbl [6];
    logic [W-1:0] r; logic z, l, d; int lat;
    tbl = '{
      '{OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'(MUL_LAT)},
      '{OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'(MUL_LAT)},
      '{OP_MUL,   32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, 1'b0, 1'b0, 8'(MUL_LAT)},
      '{OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'(MUL_LAT)},
      '{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 8'(MUL_LAT)},
      '{OP_MULHU, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'(MUL_LAT)}
    };
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, l, d, lat);
      n_vec++;
      if ({r, z, l, d, 8'(lat)} !== {tbl[i].res, tbl[i].z, tbl[i].l, tbl[i].d, tbl[i].lat}) begin
        n_err++;
        $display("FAIL mul[%0d] op=%b: got res=%h z=%b lt=%b dbz=%b lat=%0d want res=%h z=%b lt=%b dbz=%b lat=%0d",
                 i, tbl[i].op, r, z, l, d, lat, tbl[i].res, tbl[i].z, tbl[i].l, tbl[i].d, tbl[i].lat);
      end
    end
    // Pipeline must see in_ready low a few cycles into an iterative multiply.
    @(posedge clk); #1;
    in_valid = 1'b1; alu_control = OP_MUL; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== (MUL_LAT == 1)) begin
      n_err++;
      $display("FAIL mul_busy_ready: got in_ready=%b want %b", in_ready, MUL_LAT == 1);
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_div();
    vec_t tbl [14];
    logic [W-1:0] r; logic z, l, d; int lat;
    tbl = '{
      '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 8'(DIV_LAT)},
      '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'(DIV_LAT)},
      '{OP_DIVU, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 8'd1},
      '{OP_REMU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, 1'b0, 1'b1, 8'd1},
      '{OP_DIV,  32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 8'd1},
      '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b1, 8'd1},
      '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 8'd1},
      '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'd1},
      '{OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 1'b0, 1'b0, 8'(DIV_LAT)},
      '{OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 8'(DIV_LAT)},
      '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 8'(DIV_LAT)},
      '{OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'(DIV_LAT)},
      '{OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'(DIV_LAT)},
      '{OP_REMU, 32'h0000_000C, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'(DIV_LAT)}
    };
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, l, d, lat);
      n_vec++;
      if ({r, z, l, d, 8'(lat)} !== {tbl[i].res, tbl[i].z, tbl[i].l, tbl[i].d, tbl[i].lat}) begin
        n_err++;
        $display("FAIL div[%0d] op=%b: got res=%h z=%b lt=%b dbz=%b lat=%0d want res=%h z=%b lt=%b dbz=%b lat=%0d",
                 i, tbl[i].op, r, z, l, d, lat, tbl[i].res, tbl[i].z, tbl[i].l, tbl[i].d, tbl[i].lat);
      end
    end
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = OP_DIVU; a = 32'd7; b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'd9; b = 32'd3;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold_latency: got out_valid=%b want 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, result, zero, div_by_zero, in_ready} !== {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL hold[%0d]: got ov=%b res=%h z=%b dbz=%b rdy=%b want ov=1 res=ffffffff z=0 dbz=1 rdy=0",
                 i, out_valid, result, zero, div_by_zero, in_ready);
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b1; alu_control = OP_ADD; a = 32'd2; b = 32'd3;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release_ready: got in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, result, div_by_zero} !== {1'b1, 32'd5, 1'b0}) begin
      n_err++;
      $display("FAIL hold_next_op: got ov=%b res=%h dbz=%b want ov=1 res=00000005 dbz=0",
               out_valid, result, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    in_valid = 1'b1; alu_control = OP_ADD; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, result} !== {1'b1, 32'd2}) begin
      n_err++;
      $display("FAIL b2b_first: got ov=%b res=%h want ov=1 res=00000002", out_valid, result);
    end
    alu_control = OP_SUB; a = 32'd10; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, result} !== {1'b1, 32'd7}) begin
      n_err++;
      $display("FAIL b2b_second: got ov=%b res=%h want ov=1 res=00000007", out_valid, result);
    end
  endtask

  task automatic test_reset_busy();
    logic [W-1:0] r; logic z, l, d; int lat; int seen;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_control = OP_DIV; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, result, zero, div_by_zero} !== {1'b0, 32'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_busy_async: got ov=%b res=%h z=%b dbz=%b want all 0",
               out_valid, result, zero, div_by_zero);
    end
    #4 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL rst_busy_no_result: got %0d out_valid cycles want 0", seen);
    end
    run_op(OP_ADD, 32'd2, 32'd3, r, z, l, d, lat);
    n_vec++;
    if ({r, 8'(lat)} !== {32'd5, 8'd1}) begin
      n_err++;
      $display("FAIL rst_busy_add: got res=%h lat=%0d want res=00000005 lat=1", r, lat);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_base_ops();
    test_mul();
    test_div();
    test_hold();
    test_back_to_back();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
